fn_unit_arbiter: RTL and testbench
==================================

// Module: fn_unit_arbiter
//
// PURPOSE
//   Shares one registered f1 compute unit, f1(a,b,c) = (a+b) ^ c, among NREQ requesters.
//   Each requester supplies its own c or selects the default constant.
//   Round-robin arbitration; valid/ready handshakes on every request port and on the single
//   response port. Sits between the requesting datapath lanes and the shared result consumer.
//
// PARAMETERS
//   NREQ      3        number of requesters (>=2)
//   W         4        operand/result width in bits
//   DEFAULT_C 4'b1010  c used when req_c_en[i]=0; width W
//   IDW       $clog2(NREQ)  requester-id width (derived, not overridable)
//
// PORTS
//   clk        in   1        single clock, all state on posedge
//   rst        in   1        synchronous reset, active-high
//   req_valid  in   NREQ     request i presents operands
//   req_ready  out  NREQ     one-hot (or zero) grant; transfer when valid&ready
//   req_a      in   NREQ*W   operand a, lane i at [i*W +: W]
//   req_b      in   NREQ*W   operand b, same packing
//   req_c      in   NREQ*W   operand c, same packing
//   req_c_en   in   NREQ     1: use req_c lane; 0: use DEFAULT_C
//   rsp_valid  out  1        result register holds a result
//   rsp_ready  in   1        consumer accepts result this cycle
//   rsp_data   out  W        f1 result
//   rsp_id     out  IDW      index of requester that produced rsp_data
//   rsp_count  out  8        number of responses consumed (rsp_valid&rsp_ready); wraps 255->0
//
// BEHAVIOUR
// - Reset (rst=1 at posedge): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_count=0, rr pointer=0.
//   req_ready is 0 in any cycle with rst=1. Reset overrides any in-flight request/response;
//   a held result is discarded and is not counted.
// - Output register is a 1-entry pipeline stage. can_accept = !rsp_valid | rsp_ready.
// - Arbitration is combinational.
//   - If can_accept: grant the first i with req_valid[i]=1, scanning ptr, ptr+1, ...,
//     wrapping modulo NREQ.
//   - req_ready[g]=1 only for the granted g; all other req_ready bits are 0.
//   - If !can_accept or no request is valid: req_ready=0.
//   - req_ready may depend on req_valid. No requester's valid may depend on its ready.
// - On transfer (req_valid[g] & req_ready[g]) at posedge:
//   - rsp_data <= (a_g + b_g)[W-1:0] ^ c_eff, where c_eff = req_c_en[g] ? c_g : DEFAULT_C.
//     The sum is truncated to W bits; the carry is dropped.
//   - rsp_id <= g; rsp_valid <= 1; ptr <= (g==NREQ-1) ? 0 : g+1.
// - Latency: result is visible on rsp_* exactly 1 cycle after the transfer.
//   Throughput: 1 result/cycle when rsp_ready is held at 1.
// - Drain with no new transfer (rsp_valid & rsp_ready and no grant): rsp_valid <= 0.
//   rsp_data and rsp_id keep their last values.
// - Simultaneous drain + new transfer: the register is overwritten with the new result and
//   rsp_valid stays 1. No bubble.
// - Backpressure (rsp_valid & !rsp_ready): rsp_data, rsp_id and rsp_valid hold stable.
//   No grant is issued; ptr does not move.
// - ptr advances only on a transfer. Idle cycles do not rotate priority.
// - rsp_count increments by 1 on each rsp_valid&rsp_ready, with modulo-256 wrap.
// - FSM (2 states, encoded by rsp_valid):
//   - EMPTY -> FULL on transfer.
//   - FULL -> EMPTY on drain without transfer.
//   - FULL -> FULL on stall, or on drain+transfer.
//   - EMPTY -> EMPTY otherwise.
//
// TESTING
// 1. Hold rst=1 two cycles with all req_valid=1.
//    -> req_ready=0, rsp_valid=0, rsp_data=0, rsp_count=0 throughout.
// 2. Lane0 a=3, b=4, c_en=0, rsp_ready=1.
//    -> req_ready=001; next cycle rsp_data=4'hD (7^A), rsp_id=0, rsp_count=1 a cycle later.
// 3. Lane1 a=F, b=2, c=0, c_en=1.
//    -> rsp_data=4'h1 (carry dropped), rsp_id=1.
// 4. All 3 lanes valid continuously from reset, rsp_ready=1.
//    -> grants 0,1,2,0,1,2 on consecutive cycles; rsp_valid stays 1 after the first result;
//       rsp_count=6 after 6 drains.
// 5. Lane2 transfers; then rsp_ready=0 for 4 cycles with lanes 0 and 1 valid.
//    -> rsp_* stable and req_ready=000 for those cycles; next grant on release is lane 0;
//       ptr order preserved.
// 6. Assert rst for one cycle while rsp_valid=1 and rsp_ready=0.
//    -> result dropped, rsp_count unchanged at 0 (cleared), next grant starts from lane 0.
// 7. Drive 256 drains. -> rsp_count wraps to 0.

Source files
------------

// File: rtl/fn_unit_arbiter.sv
// Round-robin arbiter sharing one registered f1 unit, f1(a,b,c) = (a+b) ^ c, among NREQ lanes.
// The one-entry result register doubles as the EMPTY/FULL state, so rsp_valid is the state bit.
module fn_unit_arbiter #(
  parameter int           NREQ      = 3,
  parameter int           W         = 4,
  parameter logic [W-1:0] DEFAULT_C = 4'b1010
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  input  logic [NREQ*W-1:0]         req_c,
  input  logic [NREQ-1:0]           req_c_en,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [W-1:0]              rsp_data,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [7:0]                rsp_count
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     count_q, count_d;

  logic [W-1:0]   f1_lane [NREQ];
  logic           can_accept;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic           drain;

  // Every lane computes its own f1 result; the grant just picks one.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      logic [W-1:0] sum;
      logic [W-1:0] c_eff;
      assign sum          = req_a[gi*W +: W] + req_b[gi*W +: W];
      assign c_eff        = req_c_en[gi] ? req_c[gi*W +: W] : DEFAULT_C;
      assign f1_lane[gi]  = sum ^ c_eff;
    end
  endgenerate

  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign drain      = (state_q == FULL) && rsp_ready;

  // Scan ptr, ptr+1, ... modulo NREQ; cand is one bit wider so the wrap can't overflow.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
    if (rst || !can_accept) begin
      grant_found = 1'b0;
    end
  end

  assign req_ready = grant_found ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      EMPTY:   if (grant_found) state_d = FULL;
      FULL:    if (drain && !grant_found) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (grant_found) begin
      data_d = f1_lane[grant_idx];
      id_d   = grant_idx;
      ptr_d  = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
    if (drain) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_count = count_q;

endmodule

// File: tb/tb_fn_unit_arbiter.sv
// Bench for fn_unit_arbiter: a stimulus process predicts grants and results into a queue,
// and a monitor pops and compares every consumed response.
module tb_fn_unit_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 4;
  localparam int IDW  = $clog2(NREQ);
  localparam int DEFC = 10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*W-1:0]      req_a = '0, req_b = '0, req_c = '0;
  logic [NREQ-1:0]        req_c_en = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [W-1:0]           rsp_data;
  logic [IDW-1:0]         rsp_id;
  logic [7:0]             rsp_count;

  fn_unit_arbiter #(.NREQ(NREQ), .W(W), .DEFAULT_C(4'b1010)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_c_en(req_c_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int id; } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  int a_arr [NREQ];
  int b_arr [NREQ];
  int c_arr [NREQ];
  bit cen_arr [NREQ];

  bit model_full = 0;
  int model_ptr  = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int f1(input int a, input int b, input int c, input bit cen);
    return ((a + b) % (1 << W)) ^ (cen ? c : DEFC);
  endfunction

  // One clock of stimulus: drive after the edge, predict and check at the falling edge.
  task automatic step(input bit r, input logic [NREQ-1:0] v, input bit rr, input bit rnd);
    int exp_ready;
    int g;
    bit found;
    @(posedge clk);
    #1;
    if (rnd) begin
      for (int i = 0; i < NREQ; i++) begin
        a_arr[i]   = $urandom_range(0, (1 << W) - 1);
        b_arr[i]   = $urandom_range(0, (1 << W) - 1);
        c_arr[i]   = $urandom_range(0, (1 << W) - 1);
        cen_arr[i] = $urandom_range(0, 1) == 1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'(a_arr[i]);
      req_b[i*W +: W] = W'(b_arr[i]);
      req_c[i*W +: W] = W'(c_arr[i]);
      req_c_en[i]     = cen_arr[i];
    end
    rst = r;
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    found = 0;
    g = 0;
    if (!r && (!model_full || rr)) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && v[(model_ptr + k) % NREQ]) begin
          found = 1;
          g = (model_ptr + k) % NREQ;
        end
      end
    end
    exp_ready = found ? (1 << g) : 0;
    chk(int'(req_ready) == exp_ready, "req_ready", int'(req_ready), exp_ready);
    chk(rsp_valid == model_full, "rsp_valid", int'(rsp_valid), int'(model_full));
    $display("cycle t=%0t rst=%0d valid=%b rsp_ready=%0d req_ready=%b rsp_valid=%0d data=%h id=%0d count=%0d",
             $time, r, v, rr, req_ready, rsp_valid, rsp_data, rsp_id, rsp_count);
    if (r) begin
      model_full = 0;
      model_ptr  = 0;
      exp_q.delete();
    end else if (found) begin
      exp_q.push_back('{data: f1(a_arr[g], b_arr[g], c_arr[g], cen_arr[g]), id: g});
      model_ptr  = (g + 1) % NREQ;
      model_full = 1;
    end else if (model_full && rr) begin
      model_full = 0;
    end
  endtask

  task automatic set_lane(input int i, input int a, input int b, input int c, input bit cen);
    a_arr[i] = a; b_arr[i] = b; c_arr[i] = c; cen_arr[i] = cen;
  endtask

  // Monitor: compares every consumed result against the predicted queue head.
  logic [7:0] mon_count = 8'd0;
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk(rsp_count == mon_count, "rsp_count", int'(rsp_count), int'(mon_count));
      if (rst) begin
        mon_count = 8'd0;
      end else if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk(0, "rsp_unexpected", int'(rsp_data), -1);
        end else begin
          e = exp_q.pop_front();
          chk(int'(rsp_data) == e.data, "rsp_data", int'(rsp_data), e.data);
          chk(int'(rsp_id) == e.id, "rsp_id", int'(rsp_id), e.id);
        end
        mon_count = mon_count + 8'd1;
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) set_lane(i, 0, 0, 0, 0);
    // Reset held two cycles with every lane requesting.
    step(1, 3'b111, 1, 0);
    step(1, 3'b111, 1, 0);
    chk(rsp_data == 0, "reset_rsp_data", int'(rsp_data), 0);
    chk(rsp_id == 0, "reset_rsp_id", int'(rsp_id), 0);
    chk(rsp_count == 0, "reset_rsp_count", int'(rsp_count), 0);
    // Lane 0 with default c: (3+4)^A = D.
    set_lane(0, 3, 4, 0, 0);
    step(0, 3'b001, 1, 0);
    step(0, 3'b000, 1, 0);
    chk(rsp_data == 4'hD, "lane0_default_c", int'(rsp_data), 13);
    // Lane 1, carry dropped: (F+2)^0 = 1.
    set_lane(1, 15, 2, 0, 1);
    step(0, 3'b010, 1, 0);
    step(0, 3'b000, 1, 0);
    chk(rsp_data == 4'h1, "lane1_carry_drop", int'(rsp_data), 1);
    step(0, 3'b000, 1, 0);
    // All lanes continuously valid from reset.
    step(1, 3'b111, 1, 1);
    for (int n = 0; n < 6; n++) step(0, 3'b111, 1, 1);
    // Lane 2 transfer, then backpressure with lanes 0 and 1 waiting.
    step(0, 3'b100, 1, 1);
    for (int n = 0; n < 4; n++) step(0, 3'b011, 0, 0);
    step(0, 3'b011, 1, 0);
    step(0, 3'b000, 1, 0);
    // Reset while a result is held under backpressure.
    step(0, 3'b010, 1, 1);
    step(1, 3'b011, 0, 0);
    step(0, 3'b111, 1, 1);
    step(0, 3'b000, 1, 0);
    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) == 0, NREQ'($urandom_range(0, (1 << NREQ) - 1)),
           $urandom_range(0, 9) < 7, 1);
    end
    // Counter wrap: well over 256 drains after a reset.
    step(1, 3'b000, 1, 0);
    for (int n = 0; n < 260; n++) step(0, 3'b111, 1, 1);
    for (int n = 0; n < 3; n++) step(0, 3'b000, 1, 0);
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    chk(rsp_count == 8'd4, "count_wrapped", int'(rsp_count), 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
